// File: rtl/urv_fetch_queue.sv
// urv_fetch_queue -- instruction fetch stage of the uRV core.
//
// Generates sequential fetch addresses, issues in-order reads to instruction
// memory and buffers the returned words in a small queue. The queue head is
// presented to decode one instruction per cycle. Redirects from execute flush
// the queue and discard responses of reads that are still in flight.
//
// Ports
//   clk_i       in   1   clock, rising edge
//   rst_n_i     in   1   asynchronous active-low reset
//   f_stall_i   in   1   decode stall, head instruction is not consumed
//   x_bra_i     in   1   redirect request (1-cycle pulse)
//   x_pc_bra_i  in  32   redirect target, bits [1:0] ignored
//   im_addr_o   out 32   instruction memory read address
//   im_rd_o     out  1   read request (always accepted)
//   im_data_i   in  32   read data
//   im_valid_i  in   1   read data valid, in request order
//   f_ir_o      out 32   instruction word at queue head
//   f_pc_o      out 32   PC of f_ir_o
//   f_valid_o   out  1   head entry valid
//
// state | meaning
// ------+-------------------------------------------------------
// BOOT  | first cycle after reset, no reads issued
// RUN   | normal fetch operation (permanent)

module urv_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_pc_bra_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  // addresses of issued reads, popped as their responses return
  logic [31:0]   pcf [QUEUE_DEPTH];
  logic [PW-1:0] pcf_wr;
  logic [PW-1:0] pcf_rd;

  // instruction queue
  logic [31:0]   q_ir [QUEUE_DEPTH];
  logic [31:0]   q_pc [QUEUE_DEPTH];
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;

  logic          issue;
  logic          resp;
  logic          keep;
  logic          pop;
  logic [CW:0]   used;

  logic          unused_bits;
  assign unused_bits = ^x_pc_bra_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    resp      = 1'b0;
    keep      = 1'b0;
    pop       = 1'b0;
    used      = '0;

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase

    // a response with nothing outstanding is a protocol violation and is ignored
    resp = im_valid_i && (outstanding != '0);
    keep = resp && (drop == '0) && !x_bra_i;
    pop  = f_valid_o && !f_stall_i;

    // Credits count the head being consumed this cycle as already free, so a
    // depth-2 queue can sustain one instruction per cycle. A returning
    // response moves one unit from outstanding to count, leaving the sum as is.
    used  = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);
    issue = (state == RUN) && !x_bra_i && (used < (CW+1)'(QUEUE_DEPTH));
  end

  assign im_rd_o   = issue;
  assign im_addr_o = fetch_pc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      drop        <= '0;
      pcf_wr      <= '0;
      pcf_rd      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) pcf[i] <= '0;
    end else begin
      if (x_bra_i)    fetch_pc <= {x_pc_bra_i[31:2], 2'b00};
      else if (issue) fetch_pc <= fetch_pc + 32'd4;

      if (issue) begin
        pcf[pcf_wr] <= fetch_pc;
        pcf_wr      <= pcf_wr + PW'(1);
      end
      if (resp) pcf_rd <= pcf_rd + PW'(1);

      outstanding <= outstanding + CW'(issue) - CW'(resp);

      // every read still in flight after the redirect cycle belongs to the old path
      if (x_bra_i)                  drop <= outstanding - CW'(resp);
      else if (resp && drop != '0)  drop <= drop - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_ir[i] <= '0;
        q_pc[i] <= '0;
      end
    end else if (x_bra_i) begin
      count <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
    end else begin
      if (keep) begin
        q_ir[q_wr] <= im_data_i;
        q_pc[q_wr] <= pcf[pcf_rd];
        q_wr       <= q_wr + PW'(1);
      end
      if (pop) q_rd <= q_rd + PW'(1);
      count <= count + CW'(keep) - CW'(pop);
    end
  end

  assign f_valid_o = (count != '0);
  assign f_ir_o    = q_ir[q_rd];
  assign f_pc_o    = q_pc[q_rd];

endmodule
